// File: rtl/adder_subtractor_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_subtractor_4bit
//  Description : Registered WIDTH-bit two's-complement adder/subtractor with
//                registered carry-out and signed overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_c;

    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;

    // Subtraction is a + ~b + 1: invert b and inject en as the carry-in.
    assign w_b_eff = b ^ {WIDTH{en}};
    assign w_c[0]  = en;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign w_s[i]   = a[i] ^ w_b_eff[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & w_b_eff[i]) | (w_c[i] & (a[i] ^ w_b_eff[i]));
        end
    endgenerate

    always_comb begin
        sum_d   = w_s;
        carry_d = w_c[WIDTH];
        ovf_d   = w_c[WIDTH] ^ w_c[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_subtractor_4bit
//  Description : Scoreboard bench for adder_subtractor_4bit (directed, sweep,
//                random with mid-stream resets).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_subtractor_4bit;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    exp_t exp_q[$];
    int   total;
    int   bad;

    adder_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .en    (en),
        .sum   (sum),
        .carry (carry),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic r, input int ua, input int ub, input logic sub);
        exp_t e;
        int   full, sa, sb, sr, lim;
        lim = 1 << (WIDTH - 1);
        sa  = (ua >= lim) ? ua - (1 << WIDTH) : ua;
        sb  = (ub >= lim) ? ub - (1 << WIDTH) : ub;
        if (r) begin
            e = '0;
        end else if (!sub) begin
            full = ua + ub;
            sr   = sa + sb;
            e.s  = full[WIDTH-1:0];
            e.c  = (full >= (1 << WIDTH));
            e.o  = (sr < -lim) || (sr > lim - 1);
        end else begin
            full = ua - ub;
            sr   = sa - sb;
            e.s  = full[WIDTH-1:0];
            e.c  = (ua >= ub);
            e.o  = (sr < -lim) || (sr > lim - 1);
        end
        return e;
    endfunction

    task automatic drive_exp(input logic r, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb, input logic ven, input exp_t e);
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        en  = ven;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic ven);
        drive_exp(r, va, vb, ven, model(r, int'(va), int'(vb), ven));
    endtask

    // Monitor: one result per edge, compared one step after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({sum, carry, ovf} !== e) begin
                bad++;
                $display("FAIL result t=%0t: got sum=%b carry=%b ovf=%b, want sum=%b carry=%b ovf=%b",
                         $time, sum, carry, ovf, e.s, e.c, e.o);
            end
        end
    end

    // Directed vectors: {a, b, en, sum, carry, ovf}
    typedef struct packed {
        logic [3:0] va;
        logic [3:0] vb;
        logic       ven;
        exp_t       e;
    } vec_t;

    vec_t dir[$];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        en    = 1'b0;

        dir.push_back('{4'b1010, 4'b0101, 1'b0, '{4'b1111, 1'b0, 1'b0}});
        dir.push_back('{4'b1010, 4'b0101, 1'b1, '{4'b0101, 1'b1, 1'b1}});
        dir.push_back('{4'b1110, 4'b0111, 1'b0, '{4'b0101, 1'b1, 1'b0}});
        dir.push_back('{4'b1110, 4'b0111, 1'b1, '{4'b0111, 1'b1, 1'b1}});
        dir.push_back('{4'b0010, 4'b0001, 1'b0, '{4'b0011, 1'b0, 1'b0}});
        dir.push_back('{4'b0010, 4'b0001, 1'b1, '{4'b0001, 1'b1, 1'b0}});
        dir.push_back('{4'b0101, 4'b1110, 1'b0, '{4'b0011, 1'b1, 1'b0}});
        dir.push_back('{4'b0101, 4'b1110, 1'b1, '{4'b0111, 1'b0, 1'b0}});
        dir.push_back('{4'b1111, 4'b1111, 1'b1, '{4'b0000, 1'b1, 1'b0}});

        // Reset held two cycles with non-zero operands, then release.
        drive_exp(1'b1, 4'b1111, 4'b1111, 1'b0, '{4'b0000, 1'b0, 1'b0});
        drive_exp(1'b1, 4'b1111, 4'b1111, 1'b0, '{4'b0000, 1'b0, 1'b0});
        drive_exp(1'b0, 4'b1111, 4'b1111, 1'b0, '{4'b1110, 1'b1, 1'b0});

        // Back-to-back directed vectors, new operation every cycle.
        foreach (dir[i]) drive_exp(1'b0, dir[i].va, dir[i].vb, dir[i].ven, dir[i].e);

        // Exhaustive sweep.
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    drive(1'b0, x[3:0], y[3:0], m[0]);

        // Random stream with occasional mid-stream resets.
        for (int k = 0; k < 400; k++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 15) == 0), ra, rb, 1'($urandom_range(0, 1)));
        end

        // Drain: allow the last result to be checked.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
